dvi_tx_video_timing_gen: RTL and testbench
==========================================

Name: dvi_tx_video_timing_gen

Overview:
- Generates raster timing (hsync, vsync, den) and a selectable test pattern (RGB888) for the DVI transmit path.
- Sits directly upstream of the three per-channel TMDS encoders.
- Blue encoder receives ctrl = {vsync, hsync}; red and green encoders receive ctrl = 2'b00.
- Defaults give CEA 1080p60 at 148.5 MHz pixel clock.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (pixels)
H_SYNC, 44, hsync width (pixels)
H_BP, 148, horizontal back porch (pixels)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
CNT_W, 12, width of the h/v counters

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high
pattern_sel  in  2  00 colour bars, 01 grey ramp, 10 checkerboard, 11 solid black
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
den  out  1  data enable, high in the active region
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
frame_start  out  1  one-cycle pulse aligned with the first pixel of a frame
h_pos  out  CNT_W  registered h counter, aligned with outputs
v_pos  out  CNT_W  registered v counter, aligned with outputs

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1125).
- Region order per line and per frame: active, front porch, sync, back porch. Counter value 0 is the first active pixel / first active line.
- h_cnt counts 0..H_TOTAL-1 every clock and wraps to 0.
- v_cnt increments only when h_cnt == H_TOTAL-1, and wraps from V_TOTAL-1 to 0 on that same cycle.
- Decode terms (combinational from counters):
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - vsync changes with the line boundary, not mid-line.
  - den = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
- Latency: every output is registered and lags its counter state by exactly 1 clock. hsync, vsync, den, RGB, frame_start, h_pos and v_pos are mutually aligned.
- frame_start is high for the output cycle corresponding to (h_cnt, v_cnt) = (0, 0).
- pattern_sel is sampled into pat_q only on the counter cycle (0, 0). The new pattern takes effect from that frame's first pixel, so a mid-frame change never tears.
- Colour bars:
  - 8 bars of BAR_W = H_ACTIVE/8 pixels (240).
  - Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar index comes from a pixel counter and 3-bit index counter; no divider. Both reset at h_cnt == 0 and the index advances every BAR_W pixels.
- Grey ramp: R = G = B = h_cnt[7:0].
- Checkerboard: white when h_cnt[5] ^ v_cnt[5], else black (32x32 squares).
- Blanking: RGB is forced to 000000 whenever den is low, for every pattern.
- Reset:
  - h_cnt = 0, v_cnt = 0, pat_q = 00, bar counters = 0.
  - Outputs: den = 0, hsync = ~HS_POL, vsync = ~VS_POL, RGB = 0, frame_start = 0, h_pos = 0, v_pos = 0.
  - Reset asserted mid-frame restarts the raster at (0, 0) on the cycle reset deasserts.
  - The first output cycle after release shows frame_start = 1, den = 1, colour-bar white.

Test Plan:
- Release reset, pattern_sel = 00 -> next cycle: frame_start = 1, den = 1, RGB = FFFFFF. Output pixel 240 = FFFF00. Pixel 1919 = 000000. den falls at output h_pos 1920.
- Count over one line -> hsync active for exactly 44 clocks starting at h_pos 2008. Line period is 2200 clocks. den high for 1920 clocks on lines 0..1079.
- Count over one frame -> vsync active for lines 1084..1088, changing at h_pos 0. frame_start period is 2,475,000 clocks. den low on lines 1080..1124.
- Switch pattern_sel to 01 at v_pos 500 -> bars persist until the next frame_start. Then pixel h = 300 gives RGB = 2C2C2C. RGB = 0 at h_pos 1950.
- Checkerboard (10) -> pixel (0,0) black, (32,0) white, (32,32) black.
- Assert reset for 3 cycles at v_pos 700 -> during reset outputs read the reset values (den 0, syncs inactive). First cycle after release: frame_start = 1, h_pos = 0, v_pos = 0.

Source files
------------

// File: rtl/dvi_tx_video_timing_gen.sv
// rtl/dvi_tx_video_timing_gen.sv - raster timing and test pattern source for the DVI transmit path
module dvi_tx_video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       pattern_sel,
  output logic             hsync,
  output logic             vsync,
  output logic             den,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;
  logic [1:0]       pat_q;

  logic        frame_origin;
  logic [1:0]  pat_cur;
  logic        hs_act;
  logic        vs_act;
  logic        de_act;
  logic [23:0] pix_rgb;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Bar position tracks h_cnt incrementally so no divide by BAR_W is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
      pat_q   <= 2'b00;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        bar_px  <= '0;
        bar_idx <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (bar_px == BAR_LAST) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + 1'b1;
        end
      end
      if (frame_origin) begin
        pat_q <= pattern_sel;
      end
    end
  end

  // The pattern is captured at the frame origin and used for that very pixel.
  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign pat_cur      = frame_origin ? pattern_sel : pat_q;
  assign hs_act       = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_act       = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign de_act       = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);

  always_comb begin
    pix_rgb = 24'h000000;
    if (de_act) begin
      case (pat_cur)
        2'b00:   pix_rgb = bar_colour(bar_idx);
        2'b01:   pix_rgb = {3{h_cnt[7:0]}};
        2'b10:   pix_rgb = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
        default: pix_rgb = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      den         <= 1'b0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      frame_start <= 1'b0;
      h_pos       <= '0;
      v_pos       <= '0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      den         <= de_act;
      red         <= pix_rgb[23:16];
      green       <= pix_rgb[15:8];
      blue        <= pix_rgb[7:0];
      frame_start <= frame_origin;
      h_pos       <= h_cnt;
      v_pos       <= v_cnt;
    end
  end

endmodule

// File: tb/tb_dvi_tx_video_timing_gen.sv
// tb/tb_dvi_tx_video_timing_gen.sv - random pattern/reset stimulus against a raster arithmetic model
module tb_dvi_tx_video_timing_gen;

  localparam int HA = 64, HF = 4, HS = 6, HB = 6;
  localparam int VA = 40, VF = 2, VS = 3, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int BAR_W = HA / 8;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam int CW = 12;

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic          clock;
  logic          reset;
  logic [1:0]    pattern_sel;
  logic          hsync, vsync, den, frame_start;
  logic [7:0]    red, green, blue;
  logic [CW-1:0] h_pos, v_pos;

  dvi_tx_video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .pattern_sel(pattern_sel),
    .hsync(hsync), .vsync(vsync), .den(den),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .h_pos(h_pos), .v_pos(v_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  int       pos = 0;
  logic [1:0] frame_pat = 2'b00;
  int       cyc = 0;
  int       last_fs = 0;
  int       den_cnt = 0;
  bit       clean = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v, input logic [1:0] p);
    if (!(h < HA && v < VA)) return 24'h000000;
    case (p)
      2'b00:   return BAR_TAB[h / BAR_W];
      2'b01:   return {3{8'(h % 256)}};
      2'b10:   return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step(input logic rst, input logic [1:0] sel);
    int h, v;
    logic e_hs, e_vs, e_de, e_fs;
    logic [23:0] e_rgb;
    reset = rst;
    pattern_sel = sel;
    @(posedge clock);
    #1;
    cyc++;
    if (rst) begin
      h = 0; v = 0;
      e_hs = ~HSP; e_vs = ~VSP; e_de = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      pos = 0;
    end else begin
      h = pos % HT;
      v = pos / HT;
      if (pos == 0) frame_pat = sel;
      e_hs = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
      e_vs = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
      e_de = (h < HA && v < VA);
      e_fs = (pos == 0);
      e_rgb = model_rgb(h, v, frame_pat);
      pos = (pos + 1) % FRAME;
    end
    check("syncs", {30'd0, hsync, vsync}, {30'd0, e_hs, e_vs});
    check("den", {31'd0, den}, {31'd0, e_de});
    check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    check("rgb", {8'd0, red, green, blue}, {8'd0, e_rgb});
    check("pos", {4'd0, h_pos, 4'd0, v_pos}, {4'd0, 12'(h), 4'd0, 12'(v)});

    if (rst) begin
      clean = 1'b0;
      den_cnt = 0;
    end else begin
      if (frame_start === 1'b1) begin
        if (clean) begin
          check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
          check("den_per_frame", 32'(den_cnt), 32'(HA * VA));
        end
        last_fs = cyc;
        den_cnt = 0;
        clean = 1'b1;
      end
      if (den === 1'b1) den_cnt++;
    end
  endtask

  initial begin
    logic [1:0] sel;
    int rst_left;
    reset = 1'b1;
    pattern_sel = 2'b00;
    sel = 2'b00;
    rst_left = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
    // One full bars frame, then a reset in the middle of line 30.
    for (int i = 0; i < FRAME + 30 * HT + 17; i++) step(1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01);

    for (int i = 0; i < 5 * FRAME; i++) begin
      if ($urandom_range(0, 299) == 0) sel = 2'($urandom_range(0, 3));
      if (rst_left == 0 && $urandom_range(0, 4999) == 0) rst_left = $urandom_range(1, 4);
      if (rst_left > 0) begin
        rst_left--;
        step(1'b1, sel);
      end else begin
        step(1'b0, sel);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
